ramp_dac_spi: RTL
=================

// Module: ramp_dac_spi
// PURPOSE
//  Downstream consumer of rampgen: accepts 16-bit ramp samples and serialises each
//  to an external SPI DAC (mode 0, MSB first, one 16-bit frame per sample).
//  Handshake-driven single-sample buffer; samples offered while a frame is in
//  flight are dropped and counted. Sits between rampgen.ramp and the board DAC pins.
// PARAMETERS
//  DATA_W   16  sample / frame width in bits (>=2)
//  CLK_DIV  4   clk cycles per SCLK half-period (>=1)
//  CNT_W    8   width of saturating overrun counter
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  rst_n         in   1        asynchronous active-low reset
//  sample_in     in   DATA_W   ramp sample from rampgen
//  sample_valid  in   1        sample_in valid this cycle
//  sample_ready  out  1        block can accept a sample this cycle
//  dac_cs_n      out  1        DAC chip select, active low
//  dac_sclk      out  1        SPI clock, idles low
//  dac_mosi      out  1        SPI data, MSB first
//  busy          out  1        frame in progress (== ~sample_ready)
//  overrun_cnt   out  CNT_W    saturating count of dropped samples
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, sample_ready=1, busy=0,
//   dac_cs_n=1, dac_sclk=0, dac_mosi=0, overrun_cnt=0, shift reg=0. Reset mid-frame
//   aborts immediately: cs_n high, sclk low in the same instant; no partial resume.
//  Accept: on a clk edge with sample_valid=1 and sample_ready=1, sample_in is
//   latched into shift reg; next cycle state=SETUP.
//  Drop: each clk edge with sample_valid=1 and sample_ready=0 increments
//   overrun_cnt, saturating at 2^CNT_W-1 (no wrap).
//  FSM (all outputs registered):
//   IDLE  : cs_n=1, sclk=0, ready=1. Accept -> SETUP.
//   SETUP : cs_n=0, sclk=0, mosi=bit[DATA_W-1], ready=0; lasts CLK_DIV cycles -> SHIFT.
//   SHIFT : DATA_W bit periods, each = CLK_DIV cycles sclk=1 then CLK_DIV cycles
//           sclk=0. mosi advances to next lower bit on the sclk 1->0 transition
//           (stable across every rising edge); after last bit mosi holds bit[0].
//           After final low phase -> GAP.
//   GAP   : cs_n=1, sclk=0, mosi=0, ready=0; lasts CLK_DIV cycles -> IDLE.
//  Timing: frame = (2*DATA_W+2)*CLK_DIV cycles; sample_ready returns high exactly
//   (2*DATA_W+2)*CLK_DIV cycles after the accepting edge (136 at defaults).
//   dac_cs_n falls on the first cycle after accept; rises one SCLK half-period
//   after the last falling sclk edge.
//  Counters: half-period counter 0..CLK_DIV-1, bit counter 0..DATA_W-1; both
//   reload on state entry. No sclk glitches: sclk changes only at half-period ends.
//  Simultaneous: valid arriving on the cycle GAP->IDLE (ready=0) is a drop;
//   valid on the first IDLE cycle is accepted (back-to-back frames, no extra gap).
//  busy is exactly ~sample_ready every cycle.
// TESTING
//  1 Reset: hold rst_n=0, toggle clk -> cs_n=1, sclk=0, mosi=0, ready=1, cnt=0.
//  2 Single frame, sample 16'hA5C3, CLK_DIV=4 -> slave model on sclk rise captures
//    16'hA5C3; exactly 16 rising edges; ready back high 136 cycles after accept.
//  3 Back-to-back: valid held high with rampgen ramp 0,1,2.. -> each accepted
//    frame carries sample seen at accept edge; one accept per 136 cycles; drops counted.
//  4 Overrun saturation: CNT_W=2, 5 strobes during one frame -> overrun_cnt=3, holds.
//  5 Reset mid-frame after 7 bits -> cs_n=1 and sclk=0 asynchronously; after release
//    next sample 16'h0001 sent cleanly (slave sees 16'h0001, no stale bits).
//  6 CLK_DIV=1, sample 16'hFFFF then 16'h0000 -> frames of 34 cycles, MSB first,
//    mosi stable at every sclk rise; GAP cs_n high for 1 cycle.

Source files
------------

// File: rtl/ramp_dac_spi.sv
// Serialises 16-bit ramp samples to an SPI DAC (mode 0, MSB first) through a
// single-sample handshake buffer; samples offered mid-frame are dropped and counted.
module ramp_dac_spi #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_mosi,
  output logic              busy,
  output logic [CNT_W-1:0]  overrun_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [CNT_W-1:0] OVR_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] OVR_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t              state_r;
  logic [DIV_W-1:0]    div_r;
  logic [BIT_W-1:0]    bit_r;
  // Holds the bits not yet presented on mosi, next one at the MSB.
  logic [DATA_W-1:0]   shift_r;
  logic                cs_n_r;
  logic                sclk_r;
  logic                mosi_r;
  logic                ready_r;
  logic [CNT_W-1:0]    ovr_r;

  logic div_end_s;
  logic accept_s;
  logic drop_s;

  assign div_end_s = (div_r == DIV_LAST);
  assign accept_s  = sample_valid & ready_r;
  assign drop_s    = sample_valid & ~ready_r;

  // Frame sequencer: IDLE -> SETUP -> SHIFT (DATA_W sclk periods) -> GAP -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      div_r   <= {DIV_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      shift_r <= {DATA_W{1'b0}};
      cs_n_r  <= 1'b1;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= SETUP;
            shift_r <= {sample_in[DATA_W-2:0], 1'b0};
            mosi_r  <= sample_in[DATA_W-1];
            cs_n_r  <= 1'b0;
            ready_r <= 1'b0;
            div_r   <= {DIV_W{1'b0}};
          end else begin
            cs_n_r  <= 1'b1;
            sclk_r  <= 1'b0;
            mosi_r  <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        SETUP: begin
          if (div_end_s) begin
            state_r <= SHIFT;
            sclk_r  <= 1'b1;
            div_r   <= {DIV_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        SHIFT: begin
          if (!div_end_s) begin
            div_r <= div_r + DIV_ONE;
          end else begin
            div_r <= {DIV_W{1'b0}};
            if (sclk_r) begin
              // Falling sclk: advance mosi, except after the last bit where it holds.
              sclk_r <= 1'b0;
              if (bit_r != BIT_LAST) begin
                mosi_r  <= shift_r[DATA_W-1];
                shift_r <= {shift_r[DATA_W-2:0], 1'b0};
              end
            end else if (bit_r == BIT_LAST) begin
              state_r <= GAP;
              cs_n_r  <= 1'b1;
              mosi_r  <= 1'b0;
            end else begin
              bit_r  <= bit_r + BIT_ONE;
              sclk_r <= 1'b1;
            end
          end
        end
        GAP: begin
          if (div_end_s) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            div_r   <= {DIV_W{1'b0}};
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          div_r   <= {DIV_W{1'b0}};
          cs_n_r  <= 1'b1;
          sclk_r  <= 1'b0;
          mosi_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of samples offered while not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_r <= {CNT_W{1'b0}};
    end else if (drop_s && (ovr_r != OVR_MAX)) begin
      ovr_r <= ovr_r + OVR_ONE;
    end else begin
      ovr_r <= ovr_r;
    end
  end

  assign sample_ready = ready_r;
  assign busy         = ~ready_r;
  assign dac_cs_n     = cs_n_r;
  assign dac_sclk     = sclk_r;
  assign dac_mosi     = mosi_r;
  assign overrun_cnt  = ovr_r;

endmodule
